// File: rtl/fault_inject_pkg.sv
// rtl/fault_inject_pkg.sv - shared types and widths for the fault-injection campaign controller
package fault_inject_pkg;

    // Widths shared with the LFSR generator wrapper
    localparam int FI_IDX_W = 8;
    localparam int FI_CNT_W = 16;

    // Campaign controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4
    } fi_state_e;

endpackage

// File: rtl/fault_holdoff_timer.sv
// rtl/fault_holdoff_timer.sv - loadable down-counter timing the gap after each injection
module fault_holdoff_timer
    import fault_inject_pkg::*;
#(
    parameter int CNT_W = FI_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             clear,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Load on entry to holdoff, then count down to zero; clear wins over load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // A count of one marks the final holdoff cycle
    always_comb begin
        expired = (count == {{(CNT_W-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/fault_inject_ctrl.sv
// rtl/fault_inject_ctrl.sv - turns generator faults into paced, counted injection requests
module fault_inject_ctrl
    import fault_inject_pkg::*;
#(
    parameter int IDX_W = FI_IDX_W,
    parameter int CNT_W = FI_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_max_faults,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic [IDX_W-1:0] cfg_index_mask,
    input  logic             rnd_fault,
    input  logic [IDX_W-1:0] rnd_index,
    output logic             inj_valid,
    output logic [IDX_W-1:0] inj_index,
    input  logic             inj_ready,
    output logic [CNT_W-1:0] fault_count,
    output logic             busy,
    output logic             done
);

    fi_state_e        state;
    fi_state_e        state_nxt;

    logic [CNT_W-1:0] sh_max_faults;
    logic [CNT_W-1:0] sh_holdoff;
    logic [IDX_W-1:0] sh_index_mask;

    logic             accept;
    logic [CNT_W-1:0] count_inc;
    logic             limit_hit;
    logic             hold_expired;
    logic             hold_load;
    logic             hold_clear;

    // Saturating increment: an unlimited campaign parks at all-ones instead of wrapping
    always_comb begin
        accept    = (state == ST_ISSUE) && inj_ready;
        count_inc = (&fault_count) ? fault_count
                                   : fault_count + {{(CNT_W-1){1'b0}}, 1'b1};
        limit_hit = (sh_max_faults != '0) && (count_inc == sh_max_faults);
        hold_load = accept && (state_nxt == ST_HOLDOFF);
        hold_clear = (state == ST_IDLE);
    end

    fault_holdoff_timer #(
        .CNT_W(CNT_W)
    ) u_holdoff_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_value(sh_holdoff),
        .clear     (hold_clear),
        .expired   (hold_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a pending request is never withdrawn, so disable is only honoured after accept
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_enable) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!cfg_enable)    state_nxt = ST_IDLE;
                else if (rnd_fault) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (inj_ready) begin
                    if (limit_hit)              state_nxt = ST_DONE;
                    else if (!cfg_enable)       state_nxt = ST_IDLE;
                    else if (sh_holdoff != '0)  state_nxt = ST_HOLDOFF;
                    else                        state_nxt = ST_ARMED;
                end
            end
            ST_HOLDOFF: begin
                if (!cfg_enable)       state_nxt = ST_IDLE;
                else if (hold_expired) state_nxt = ST_ARMED;
            end
            ST_DONE: begin
                if (!cfg_enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decode the registered state only, so no input reaches them combinationally
    always_comb begin
        inj_valid = (state == ST_ISSUE);
        busy      = (state == ST_ARMED) || (state == ST_ISSUE) || (state == ST_HOLDOFF);
        done      = (state == ST_DONE);
    end

    // Shadow config at campaign start, capture the masked site, count accepted injections
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_max_faults <= '0;
            sh_holdoff    <= '0;
            sh_index_mask <= '0;
            inj_index     <= '0;
            fault_count   <= '0;
        end else begin
            if ((state == ST_IDLE) && (state_nxt == ST_ARMED)) begin
                sh_max_faults <= cfg_max_faults;
                sh_holdoff    <= cfg_holdoff;
                sh_index_mask <= cfg_index_mask;
                fault_count   <= '0;
            end
            if ((state == ST_ARMED) && (state_nxt == ST_ISSUE)) begin
                inj_index <= rnd_index & sh_index_mask;
            end
            if (accept) begin
                fault_count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// tb/tb_fault_inject_ctrl.sv - randomized and directed bench with a campaign-level reference model
module tb_fault_inject_ctrl;
    import fault_inject_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [15:0] cfg_max_faults;
    logic [15:0] cfg_holdoff;
    logic [7:0]  cfg_index_mask;
    logic        rnd_fault;
    logic [7:0]  rnd_index;
    logic        inj_valid;
    logic [7:0]  inj_index;
    logic        inj_ready;
    logic [15:0] fault_count;
    logic        busy;
    logic        done;

    logic        cfg_enable4;
    logic [3:0]  cfg_max_faults4;
    logic [3:0]  cfg_holdoff4;
    logic        inj_valid4;
    logic [7:0]  inj_index4;
    logic [3:0]  fault_count4;
    logic        busy4;
    logic        done4;

    always #5 clk = ~clk;

    fault_inject_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_max_faults(cfg_max_faults),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_index_mask(cfg_index_mask),
        .rnd_fault     (rnd_fault),
        .rnd_index     (rnd_index),
        .inj_valid     (inj_valid),
        .inj_index     (inj_index),
        .inj_ready     (inj_ready),
        .fault_count   (fault_count),
        .busy          (busy),
        .done          (done)
    );

    fault_inject_ctrl #(.IDX_W(8), .CNT_W(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable4),
        .cfg_max_faults(cfg_max_faults4),
        .cfg_holdoff   (cfg_holdoff4),
        .cfg_index_mask(8'hFF),
        .rnd_fault     (rnd_fault),
        .rnd_index     (rnd_index),
        .inj_valid     (inj_valid4),
        .inj_index     (inj_index4),
        .inj_ready     (inj_ready),
        .fault_count   (fault_count4),
        .busy          (busy4),
        .done          (done4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // campaign-level model: is a campaign running, has it hit its limit,
    // is a request outstanding, how many idle cycles remain, how many accepts
    bit         m_active;
    bit         m_finished;
    bit         m_pending;
    logic [7:0] m_idx;
    int         m_gap;
    int         m_count;
    int         m_lim;
    int         m_hold;
    logic [7:0] m_mask;

    int cyc       = 0;
    int last_acc  = -1;
    int exp_space = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_finished = 0; m_pending = 0; m_idx = 8'h00;
        m_gap = 0; m_count = 0; m_lim = 0; m_hold = 0; m_mask = 8'h00;
    endtask

    task automatic tick();
        bit         r, en, flt, rdy, dut_acc;
        logic [7:0] ridx, mk;
        logic [15:0] mx, hd;
        r = rst; en = cfg_enable; flt = rnd_fault; rdy = inj_ready;
        ridx = rnd_index; mk = cfg_index_mask; mx = cfg_max_faults; hd = cfg_holdoff;
        dut_acc = inj_valid & inj_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (dut_acc && exp_space != 0) begin
            if (last_acc >= 0) check("accept_spacing", cyc - last_acc, exp_space);
            last_acc = cyc;
        end
        if (!r) begin
            model_reset();
        end else if (!m_active) begin
            if (en) begin
                m_active = 1; m_finished = 0; m_count = 0; m_gap = 0;
                m_lim = mx; m_hold = hd; m_mask = mk;
            end
        end else if (m_finished) begin
            if (!en) begin m_active = 0; m_finished = 0; end
        end else if (m_pending) begin
            if (rdy) begin
                m_pending = 0;
                if (m_count != 16'hFFFF) m_count++;
                if (m_lim != 0 && m_count == m_lim) m_finished = 1;
                else if (!en) m_active = 0;
                else m_gap = m_hold;
            end
        end else if (m_gap > 0) begin
            if (!en) begin m_active = 0; m_gap = 0; end
            else m_gap--;
        end else begin
            if (!en) m_active = 0;
            else if (flt) begin m_pending = 1; m_idx = ridx & m_mask; end
        end
        check("busy", busy, m_active && !m_finished);
        check("done", done, m_active && m_finished);
        check("inj_valid", inj_valid, m_pending);
        check("inj_index", inj_index, m_idx);
        check("fault_count", fault_count, m_count);
    endtask

    task automatic go_idle();
        exp_space = 0; last_acc = -1;
        cfg_enable = 0; rnd_fault = 0; inj_ready = 1;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] idx_tab [3];
        idx_tab[0] = 8'h12; idx_tab[1] = 8'h34; idx_tab[2] = 8'h56;
        model_reset();

        // reset held with enable and fault asserted
        rst = 0; cfg_enable = 1; rnd_fault = 1; rnd_index = 8'h5A; inj_ready = 1;
        cfg_max_faults = 16'd0; cfg_holdoff = 16'd0; cfg_index_mask = 8'hFF;
        cfg_enable4 = 0; cfg_max_faults4 = 4'd0; cfg_holdoff4 = 4'd0;
        repeat (2) tick();
        check("rst_valid", inj_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fault_count, 16'd0);
        rst = 1;
        tick();
        check("armed_after_rst", busy, 1'b1);
        check("count_after_rst", fault_count, 16'd0);
        go_idle();

        // basic handshake, limit 3
        cfg_max_faults = 16'd3; cfg_holdoff = 16'd0; cfg_index_mask = 8'hFF;
        cfg_enable = 1; inj_ready = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            rnd_fault = 1; rnd_index = idx_tab[i];
            tick();
            check("basic_valid", inj_valid, 1'b1);
            check("basic_index", inj_index, idx_tab[i]);
            rnd_fault = 0;
            tick();
            check("basic_drop", inj_valid, 1'b0);
        end
        check("basic_count", fault_count, 16'd3);
        check("basic_done", done, 1'b1);
        go_idle();

        // backpressure with mask
        cfg_max_faults = 16'd0; cfg_index_mask = 8'h0F; cfg_enable = 1; inj_ready = 0;
        tick();
        rnd_fault = 1; rnd_index = 8'hA7;
        tick();
        rnd_fault = 0;
        for (int i = 0; i < 4; i++) begin
            rnd_index = 8'($urandom);
            tick();
            check("bp_valid", inj_valid, 1'b1);
            check("bp_index", inj_index, 8'h07);
        end
        inj_ready = 1;
        tick();
        check("bp_accepted", inj_valid, 1'b0);
        check("bp_count", fault_count, 16'd1);
        go_idle();

        // holdoff 4 with fault held, then a mid-campaign holdoff change, then re-enable
        cfg_max_faults = 16'd0; cfg_holdoff = 16'd4; cfg_index_mask = 8'hFF;
        cfg_enable = 1; inj_ready = 1; rnd_fault = 1;
        exp_space = 6; last_acc = -1;
        repeat (20) tick();
        cfg_holdoff = 16'd0;
        repeat (20) tick();
        go_idle();
        cfg_enable = 1; rnd_fault = 1; exp_space = 2; last_acc = -1;
        repeat (10) tick();
        go_idle();

        // disable during ISSUE with backpressure
        cfg_holdoff = 16'd0; cfg_enable = 1; inj_ready = 0;
        tick();
        rnd_fault = 1;
        tick();
        rnd_fault = 0; cfg_enable = 0;
        repeat (3) begin
            tick();
            check("dis_held", inj_valid, 1'b1);
        end
        inj_ready = 1;
        tick();
        check("dis_accept_valid", inj_valid, 1'b0);
        check("dis_accept_busy", busy, 1'b0);
        go_idle();

        // disable during HOLDOFF
        cfg_holdoff = 16'd5; cfg_enable = 1; inj_ready = 1;
        tick();
        rnd_fault = 1;
        tick();
        rnd_fault = 0;
        tick();
        check("hold_busy", busy, 1'b1);
        cfg_enable = 0;
        tick();
        check("hold_dis_busy", busy, 1'b0);
        go_idle();

        // reset mid-handshake drops the request asynchronously
        cfg_holdoff = 16'd0; cfg_enable = 1; inj_ready = 0;
        tick();
        rnd_fault = 1;
        tick();
        check("pre_rst_valid", inj_valid, 1'b1);
        #2 rst = 0;
        #1 check("async_rst_valid", inj_valid, 1'b0);
        tick();
        rst = 1;
        go_idle();

        // randomized campaigns with config churning every cycle
        cfg_enable = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
            rnd_fault      = ($urandom_range(0, 3) == 0);
            rnd_index      = 8'($urandom);
            inj_ready      = ($urandom_range(0, 2) != 0);
            cfg_max_faults = 16'($urandom_range(0, 5));
            cfg_holdoff    = 16'($urandom_range(0, 3));
            cfg_index_mask = 8'($urandom);
            tick();
        end
        go_idle();

        // saturation of a 4-bit unlimited campaign
        cfg_enable4 = 1; rnd_fault = 1; inj_ready = 1;
        repeat (40) tick();
        check("sat_count", fault_count4, 4'hF);
        check("sat_not_done", done4, 1'b0);
        repeat (6) tick();
        check("sat_hold", fault_count4, 4'hF);
        cfg_enable4 = 0;
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_inject_ctrl.md
# fault_inject_ctrl

Campaign controller for fault injection. It consumes the `fault`/`index` stream of the LFSR fault generator and turns each generated fault into one valid/ready injection request toward the target fault-site decoder. It enforces a configurable holdoff between injections and a maximum fault count per campaign. It sits between the generator instance and the fault-site mux in the subsystem's fault-injection wrapper.

## Interface
- `IDX_W`, default 8: index width; must equal the generator index width.
- `CNT_W`, default 16: width of the fault counter, the limit and the holdoff.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_enable` in 1: campaign enable. Level-sensitive.
- `cfg_max_faults` in CNT_W: fault limit per campaign. 0 = unlimited.
- `cfg_holdoff` in CNT_W: idle cycles forced after each accepted injection.
- `cfg_index_mask` in IDX_W: AND-mask applied to the generated index.
- `rnd_fault` in 1: generator `fault` output.
- `rnd_index` in IDX_W: generator `index` output.
- `inj_valid` out 1: injection request.
- `inj_index` out IDX_W: fault site, stable while `inj_valid` is high.
- `inj_ready` in 1: target accepts the request.
- `fault_count` out CNT_W: faults accepted in the current campaign.
- `busy` out 1: high in ARMED, ISSUE and HOLDOFF.
- `done` out 1: high in DONE.

## Operation
- States:
  - IDLE: no campaign.
  - ARMED: waiting for `rnd_fault`.
  - ISSUE: `inj_valid` high.
  - HOLDOFF: counting the gap after an injection.
  - DONE: limit reached.
- Shadow configuration:
  - IDLE→ARMED occurs when `cfg_enable`=1 in IDLE.
  - On that transition the block latches `cfg_max_faults`, `cfg_holdoff` and `cfg_index_mask` into shadow registers, and clears `fault_count` to 0.
  - Config changes mid-campaign have no effect until the next IDLE→ARMED.
- ARMED:
  - If `rnd_fault`=1 is sampled, go to ISSUE and latch `inj_index` = `rnd_index` & mask.
  - If `cfg_enable`=0, go to IDLE.
- ISSUE:
  - `inj_valid`=1, and `inj_index` is held constant.
  - The request is never withdrawn. `cfg_enable`=0 does not abort it: the handshake completes first, then the block goes to IDLE.
  - On `inj_valid`&`inj_ready`, `fault_count` increments. Next state, in priority order:
    1. DONE, if the limit is nonzero and the new count equals the limit.
    2. IDLE, if `cfg_enable`=0.
    3. HOLDOFF, if shadow holdoff ≠ 0.
    4. ARMED otherwise.
- HOLDOFF:
  - Lasts exactly shadow-holdoff cycles, then goes to ARMED.
  - `rnd_fault` pulses during holdoff are dropped, not queued.
  - `cfg_enable`=0 goes to IDLE immediately.
- DONE: `done`=1. Goes to IDLE when `cfg_enable`=0. `fault_count` is retained.
- Unlimited campaign (limit 0): `fault_count` saturates at all-ones. It does not wrap.

## Timing
- Reset values:
  - State IDLE.
  - `inj_valid`=0, `inj_index`=0, `fault_count`=0, `busy`=0, `done`=0.
  - Shadow registers 0.
- All outputs are registered. There is no combinational path from `inj_ready` or `rnd_*` to any output.
- Latency:
  - `cfg_enable` rising in IDLE → `busy`=1 next cycle.
  - `rnd_fault` sampled in ARMED → `inj_valid`=1 next cycle.
  - Accept edge → `inj_valid`=0 and `fault_count`+1 visible next cycle.
  - Minimum spacing between accepts is holdoff+2 cycles (holdoff=0: 2 cycles).
- Reset asserted mid-handshake drops `inj_valid` asynchronously. The target must tolerate an unaccepted request vanishing on reset.

## Structure
- Package `fault_inject_pkg`:
  - State enum (IDLE, ARMED, ISSUE, HOLDOFF, DONE).
  - `FI_IDX_W`=8 and `FI_CNT_W`=16 constants, shared with the generator wrapper.
- One sub-module, `fault_holdoff_timer`: loadable CNT_W down-counter with `load`, `clear` and `expired` (`expired` high on the last holdoff cycle).
- The wrapper instantiates the existing LFSR generator next to this block. This block does not instantiate it, so benches can drive `rnd_*` directly.

## Test plan
- Reset: hold `rst`=0 with `cfg_enable`=1 and `rnd_fault`=1 → all outputs 0. Release → ARMED next cycle with `fault_count`=0.
- Basic handshake:
  - Setup: limit 3, holdoff 0, mask 8'hFF, `inj_ready` tied 1.
  - Stimulus: pulse `rnd_fault` with indices 8'h12, 8'h34, 8'h56.
  - Response: three 1-cycle `inj_valid` pulses with those indices, then `fault_count`=3 and `done`=1.
- Backpressure and mask:
  - Setup: mask 8'h0F, `rnd_index`=8'hA7, `inj_ready` low for 5 cycles.
  - Response: `inj_valid` and `inj_index`=8'h07 stable for all 5 cycles, accepted on the 6th.
  - Then toggle `rnd_index` during the wait → `inj_index` unchanged.
- Holdoff:
  - Setup: holdoff 4, `rnd_fault` held 1.
  - Response: accept edges exactly 6 cycles apart, and no request during HOLDOFF.
- Disable:
  - Drop `cfg_enable` during ISSUE with `inj_ready`=0 → request held. Raise `inj_ready` → one accept, then IDLE with `busy`=0.
  - Drop `cfg_enable` in HOLDOFF → IDLE the next cycle.
- Config shadowing and saturation:
  - Change `cfg_holdoff` from 4 to 0 mid-campaign → spacing stays 6 cycles until re-enable.
  - Limit 0 with CNT_W forced to 4 → `fault_count` stops at 4'hF.
